priority_encoder_drain: RTL

Parametrised, registered successor to the fixed 8:3 combinational priority encoders. Captures a WIDTH-bit request vector through a valid/ready load handshake, then emits the index of every set bit one at a time, in priority order, through a valid/ready output handshake, clearing each bit as it is consumed. Priority direction is selectable per load. Sits between request-collecting logic, such as interrupt or flag registers, and a downstream consumer that services one index per transaction.

---
 rtl/priority_encoder_drain_if.sv | 32 +++
 rtl/priority_encoder_drain.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/priority_encoder_drain_if.sv
// Load and index handshakes of the priority encoder drain, bundled as one port.
// The master side collects requests and consumes indices; the slave side is the encoder.
interface priority_encoder_drain_if #(
  parameter int WIDTH = 8
);
  localparam int INDEX_WIDTH = $clog2(WIDTH);

  logic                   Enable_In;
  logic [WIDTH-1:0]       Data_In;
  logic                   Priority_Mode_In;
  logic                   Load_Valid_In;
  logic                   Load_Ready_Out;
  logic                   Index_Valid_Out;
  logic                   Index_Ready_In;
  logic [INDEX_WIDTH-1:0] Index_Out;
  logic                   Last_Out;
  logic [INDEX_WIDTH:0]   Count_Out;
  logic                   Zero_Load_Out;
  logic                   Busy_Out;

  modport master (
    output Enable_In, Data_In, Priority_Mode_In, Load_Valid_In, Index_Ready_In,
    input  Load_Ready_Out, Index_Valid_Out, Index_Out, Last_Out, Count_Out,
           Zero_Load_Out, Busy_Out
  );

  modport slave (
    input  Enable_In, Data_In, Priority_Mode_In, Load_Valid_In, Index_Ready_In,
    output Load_Ready_Out, Index_Valid_Out, Index_Out, Last_Out, Count_Out,
           Zero_Load_Out, Busy_Out
  );
endinterface

// File: rtl/priority_encoder_drain.sv
// Registered priority encoder: captures a request vector, then emits the index of
// every set bit one per transaction in the priority order chosen at load time,
// clearing each bit as it is consumed. Index, last and count outputs are decoded
// from registered state only, so no input reaches Index_Out combinationally.
module priority_encoder_drain #(
  parameter int WIDTH = 8
) (
  input  logic                     Clock_In,
  input  logic                     Reset_In,
  priority_encoder_drain_if.slave  bus
);

  localparam int INDEX_WIDTH = $clog2(WIDTH);
  localparam int COUNT_WIDTH = INDEX_WIDTH + 1;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_DRAIN = 1'b1
  } state_e;

  state_e                 state_q, state_d;
  logic [WIDTH-1:0]       pending_q, pending_d;
  logic                   mode_q, mode_d;
  logic                   zero_pulse_q, zero_pulse_d;

  logic                   load_ready_s;
  logic                   index_valid_s;
  logic                   load_fire_s;
  logic                   pop_fire_s;
  logic                   last_s;
  logic [INDEX_WIDTH-1:0] index_s;
  logic [INDEX_WIDTH-1:0] sel_index_s;
  logic [COUNT_WIDTH-1:0] count_s;

  // Number of set bits in a request vector.
  function automatic logic [COUNT_WIDTH-1:0] popcount(input logic [WIDTH-1:0] vec);
    logic [COUNT_WIDTH-1:0] cnt;
    cnt = {COUNT_WIDTH{1'b0}};
    for (int i = 0; i < WIDTH; i++) begin
      cnt = cnt + {{(COUNT_WIDTH-1){1'b0}}, vec[i]};
    end
    return cnt;
  endfunction

  // Index of the highest-priority set bit: lowest index when high_first is 0,
  // highest index when it is 1. The scan direction makes the last hit the winner.
  function automatic logic [INDEX_WIDTH-1:0] select_index(input logic [WIDTH-1:0] vec,
                                                          input logic high_first);
    logic [INDEX_WIDTH-1:0] idx;
    idx = {INDEX_WIDTH{1'b0}};
    for (int i = 0; i < WIDTH; i++) begin
      if (high_first) begin
        idx = vec[i] ? INDEX_WIDTH'(i) : idx;
      end else begin
        idx = vec[WIDTH-1-i] ? INDEX_WIDTH'(WIDTH-1-i) : idx;
      end
    end
    return idx;
  endfunction

  assign load_fire_s = bus.Load_Valid_In & load_ready_s;
  assign pop_fire_s  = index_valid_s & bus.Index_Ready_In;

  // State register: asynchronous reset discards any pending requests.
  always_ff @(posedge Clock_In or posedge Reset_In) begin
    if (Reset_In) begin
      state_q      <= ST_IDLE;
      pending_q    <= {WIDTH{1'b0}};
      mode_q       <= 1'b0;
      zero_pulse_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      mode_q       <= mode_d;
      zero_pulse_q <= zero_pulse_d;
    end
  end

  // Next-state logic: load in IDLE, clear one bit per pop in DRAIN, freeze when disabled.
  always_comb begin
    state_d      = state_q;
    pending_d    = pending_q;
    mode_d       = mode_q;
    zero_pulse_d = zero_pulse_q;
    if (bus.Enable_In) begin
      case (state_q)
        ST_IDLE: begin
          zero_pulse_d = 1'b0;
          if (load_fire_s) begin
            pending_d = bus.Data_In;
            mode_d    = bus.Priority_Mode_In;
            if (bus.Data_In != {WIDTH{1'b0}}) begin
              state_d = ST_DRAIN;
            end else begin
              zero_pulse_d = 1'b1;
            end
          end else begin
            pending_d = pending_q;
          end
        end
        ST_DRAIN: begin
          zero_pulse_d = 1'b0;
          if (pop_fire_s) begin
            pending_d = pending_q & ~({{(WIDTH-1){1'b0}}, 1'b1} << index_s);
            if (last_s) begin
              state_d = ST_IDLE;
            end else begin
              state_d = ST_DRAIN;
            end
          end else begin
            pending_d = pending_q;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Output decode from registered state; only the handshake qualifiers see Enable_In.
  always_comb begin
    load_ready_s  = 1'b0;
    index_valid_s = 1'b0;
    index_s       = {INDEX_WIDTH{1'b0}};
    last_s        = 1'b0;
    count_s       = popcount(pending_q);
    sel_index_s   = select_index(pending_q, mode_q);
    case (state_q)
      ST_IDLE: begin
        load_ready_s = bus.Enable_In;
      end
      ST_DRAIN: begin
        index_valid_s = bus.Enable_In;
        index_s       = sel_index_s;
        last_s        = (count_s == COUNT_WIDTH'(1));
      end
      default: begin
        load_ready_s = 1'b0;
      end
    endcase
  end

  assign bus.Load_Ready_Out  = load_ready_s;
  assign bus.Index_Valid_Out = index_valid_s;
  assign bus.Index_Out       = index_s;
  assign bus.Last_Out        = last_s;
  assign bus.Count_Out       = count_s;
  assign bus.Zero_Load_Out   = zero_pulse_q;
  assign bus.Busy_Out        = (state_q == ST_DRAIN);

endmodule
